// File: rtl/ch_mux_scheduler_pkg.sv
// ch_mux_scheduler shared definitions: register map,
// CTRL field positions, FSM encoding and slot config layout.
package ch_mux_sched_pkg;

    localparam logic [3:0] ADDR_CFG_BASE   = 4'd0;
    localparam logic [3:0] ADDR_DWELL_BASE = 4'd1;
    localparam int         ADDR_STRIDE     = 2;
    localparam logic [3:0] ADDR_CTRL       = 4'd8;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_LAST_LSB = 1;
    localparam int CTRL_LAST_MSB = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] sel;
    } slot_cfg_t;

endpackage

// File: rtl/ch_mux_scheduler_pps_sync_edge.sv
// Two-flop synchronizer for an asynchronous pulse followed by a
// registered rising-edge detector producing a one-cycle pulse.
module pps_sync_edge
    import ch_mux_sched_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/ch_mux_scheduler.sv
// Time-sequenced channel mux: steps through a slot table of
// {enable, selector} entries, switching only on PPS ticks.
module ch_mux_scheduler
    import ch_mux_sched_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int DWELL_W = 8
) (
    input  logic       i_clk_10,
    input  logic       i_rst,
    input  logic       i_pps_raw,
    input  logic       i_cfg_we,
    input  logic [3:0] i_cfg_addr,
    input  logic [7:0] i_cfg_data,
    output logic [3:0] o_enable,
    output logic [3:0] o_selector,
    output logic [1:0] o_slot,
    output logic       o_busy,
    output logic       o_pps_tick
);

    localparam int         IDX_W    = (N_SLOTS > 2) ? 2 : 1;
    localparam logic [1:0] LAST_MAX = 2'(N_SLOTS - 1);

    logic w_tick;

    pps_sync_edge u_pps (
        .i_clk   (i_clk_10),
        .i_rst   (i_rst),
        .i_async (i_pps_raw),
        .o_pulse (w_tick)
    );

    slot_cfg_t          r_cfg   [N_SLOTS];
    logic [DWELL_W-1:0] r_dwell [N_SLOTS];
    logic               r_run;
    logic [1:0]         r_last;
    logic [1:0]         r_state;
    logic [1:0]         r_slot;
    logic [DWELL_W-1:0] r_cnt;
    slot_cfg_t          r_out;

    logic               w_tbl_we;
    logic               w_ctrl_we;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [1:0]         w_last_raw;
    logic [1:0]         w_last_wr;
    logic               w_run_next;
    logic [1:0]         w_next_slot;
    logic [1:0]         w_load_slot;
    logic [IDX_W-1:0]   w_load_idx;
    logic [DWELL_W-1:0] w_load_cnt;

    assign w_tbl_we   = i_cfg_we && (i_cfg_addr < 4'(ADDR_STRIDE * N_SLOTS));
    assign w_ctrl_we  = i_cfg_we && (i_cfg_addr == ADDR_CTRL);
    assign w_wr_idx   = i_cfg_addr[IDX_W:1];
    assign w_last_raw = i_cfg_data[CTRL_LAST_MSB:CTRL_LAST_LSB];
    assign w_last_wr  = (w_last_raw > LAST_MAX) ? LAST_MAX : w_last_raw;
    assign w_run_next = w_ctrl_we ? i_cfg_data[CTRL_RUN_BIT] : r_run;

    // A shrunk LAST_SLOT below the active slot forces the wrap to 0.
    assign w_next_slot = (r_slot >= r_last) ? 2'd0 : r_slot + 2'd1;
    assign w_load_slot = (r_state == ST_ARM) ? 2'd0 : w_next_slot;
    assign w_load_idx  = w_load_slot[IDX_W-1:0];
    assign w_load_cnt  = (r_dwell[w_load_idx] == '0) ?
                         DWELL_W'(1) : r_dwell[w_load_idx];

    always_ff @(posedge i_clk_10) begin
        if (!i_rst) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                r_cfg[k]   <= '0;
                r_dwell[k] <= '0;
            end
            r_run  <= 1'b0;
            r_last <= 2'd0;
        end else begin
            if (w_tbl_we) begin
                if (i_cfg_addr[0] == ADDR_DWELL_BASE[0])
                    r_dwell[w_wr_idx] <= DWELL_W'(i_cfg_data);
                else
                    r_cfg[w_wr_idx] <= slot_cfg_t'(i_cfg_data);
            end
            if (w_ctrl_we) begin
                r_run  <= i_cfg_data[CTRL_RUN_BIT];
                r_last <= w_last_wr;
            end
        end
    end

    // Stop takes priority over any tick arriving on the same edge.
    always_ff @(posedge i_clk_10) begin
        if (!i_rst || !w_run_next) begin
            r_state <= ST_IDLE;
            r_slot  <= 2'd0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            unique case (1'b1)
                (r_state == ST_IDLE): begin
                    r_state <= ST_ARM;
                end
                (r_state == ST_ARM),
                (r_state == ST_DWELL): begin
                    if (w_tick) begin
                        if (r_state == ST_ARM || r_cnt <= DWELL_W'(1)) begin
                            r_state <= ST_DWELL;
                            r_slot  <= w_load_slot;
                            r_out   <= r_cfg[w_load_idx];
                            r_cnt   <= w_load_cnt;
                        end else begin
                            r_cnt <= r_cnt - DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_enable   = r_out.en;
    assign o_selector = r_out.sel;
    assign o_slot     = r_slot;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_pps_tick = w_tick;

endmodule

// File: tb/tb_ch_mux_scheduler.sv
// Directed self-checking bench for ch_mux_scheduler.
// Observed value packs {o_slot, o_enable, o_selector}.
module tb_ch_mux_scheduler;

    logic       clk;
    logic       rst;
    logic       raw;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] o_enable;
    logic [3:0] o_selector;
    logic [1:0] o_slot;
    logic       o_busy;
    logic       o_pps_tick;

    int checks   = 0;
    int failures = 0;

    ch_mux_scheduler #(.N_SLOTS(4), .DWELL_W(8)) dut (
        .i_clk_10   (clk),
        .i_rst      (rst),
        .i_pps_raw  (raw),
        .i_cfg_we   (we),
        .i_cfg_addr (addr),
        .i_cfg_data (data),
        .o_enable   (o_enable),
        .o_selector (o_selector),
        .o_slot     (o_slot),
        .o_busy     (o_busy),
        .o_pps_tick (o_pps_tick)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        we = 1'b1;
        addr = a;
        data = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // 150 ns raw pulse, offset from the clock; optional write on the tick cycle.
    task automatic pps(input bit w, input logic [3:0] a, input logic [7:0] d,
                       output int ticks, output int lat,
                       output logic [7:0] pre, output logic [9:0] post);
        ticks = 0;
        lat = 0;
        pre = 'x;
        post = 'x;
        fork
            begin
                #37 raw = 1'b1;
                #150 raw = 1'b0;
            end
        join_none
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lat != 0 && c == lat + 1) begin
                post = {o_slot, o_enable, o_selector};
                we = 1'b0;
            end
            if (o_pps_tick) begin
                ticks++;
                if (lat == 0) begin
                    lat = c;
                    pre = {o_enable, o_selector};
                    if (w) begin
                        we = 1'b1;
                        addr = a;
                        data = d;
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        raw = 1'b0;
        we = 1'b0;
        addr = '0;
        data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_slot, o_enable, o_selector} !== 10'h000) begin
            failures++;
            $display("FAIL reset_out got=%h exp=000", {o_slot, o_enable, o_selector});
        end
        checks++;
        if (o_busy !== 1'b0 || o_pps_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b tick=%b exp 0 0", o_busy, o_pps_tick);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_slot;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        wr(4'd0, 8'h42);
        wr(4'd1, 8'd2);
        wr(4'd8, 8'h01);
        checks++;
        if (o_busy !== 1'b1 || o_enable !== 4'h0) begin
            failures++;
            $display("FAIL arm_state got busy=%b en=%h exp busy=1 en=0", o_busy, o_enable);
        end
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (t !== 1 || l !== 3) begin
            failures++;
            $display("FAIL tick_count_latency got ticks=%0d lat=%0d exp 1 3", t, l);
        end
        checks++;
        if (pr !== 8'h00) begin
            failures++;
            $display("FAIL tick_to_out_pre got=%h exp=00", pr);
        end
        checks++;
        if (po !== 10'h042) begin
            failures++;
            $display("FAIL single_first got=%h exp=042", po);
        end
        wr(4'd0, 8'h43);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h042) begin
            failures++;
            $display("FAIL single_hold got=%h exp=042", po);
        end
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h043) begin
            failures++;
            $display("FAIL single_reload got=%h exp=043", po);
        end
        wr(4'd8, 8'h00);
        checks++;
        if (o_busy !== 1'b0 || {o_enable, o_selector} !== 8'h00) begin
            failures++;
            $display("FAIL single_stop got busy=%b out=%h exp 0 00", o_busy, {o_enable, o_selector});
        end
    endtask

    task automatic test_sequence;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        logic [9:0] exp_seq [4];
        exp_seq = '{10'h011, 10'h122, 10'h244, 10'h011};
        wr(4'd0, 8'h11);
        wr(4'd1, 8'd1);
        wr(4'd2, 8'h22);
        wr(4'd3, 8'd1);
        wr(4'd4, 8'h44);
        wr(4'd5, 8'd1);
        wr(4'd8, 8'h05);
        for (int i = 0; i < 4; i++) begin
            pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
            checks++;
            if (po !== exp_seq[i] || t !== 1) begin
                failures++;
                $display("FAIL seq_%0d got=%h ticks=%0d exp=%h ticks=1", i, po, t, exp_seq[i]);
            end
        end
    endtask

    task automatic test_dwell_zero;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        logic [9:0] exp_seq [3];
        exp_seq = '{10'h122, 10'h244, 10'h011};
        wr(4'd3, 8'd0);
        for (int i = 0; i < 3; i++) begin
            pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
            checks++;
            if (po !== exp_seq[i]) begin
                failures++;
                $display("FAIL dwell0_%0d got=%h exp=%h", i, po, exp_seq[i]);
            end
        end
    endtask

    task automatic test_simultaneous_write;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        logic [9:0] exp_seq [3];
        exp_seq = '{10'h244, 10'h011, 10'h188};
        pps(1'b1, 4'd2, 8'h88, t, l, pr, po);
        checks++;
        if (po !== 10'h122) begin
            failures++;
            $display("FAIL simul_old got=%h exp=122", po);
        end
        for (int i = 0; i < 3; i++) begin
            pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
            checks++;
            if (po !== exp_seq[i]) begin
                failures++;
                $display("FAIL simul_pass_%0d got=%h exp=%h", i, po, exp_seq[i]);
            end
        end
    endtask

    task automatic test_last_shrink;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        wr(4'd8, 8'h03);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h011) begin
            failures++;
            $display("FAIL last1_wrap got=%h exp=011", po);
        end
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h188) begin
            failures++;
            $display("FAIL last1_slot1 got=%h exp=188", po);
        end
        wr(4'd8, 8'h01);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h011) begin
            failures++;
            $display("FAIL last0_wrap got=%h exp=011", po);
        end
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h011) begin
            failures++;
            $display("FAIL last0_stay got=%h exp=011", po);
        end
    endtask

    task automatic test_stop_on_tick;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        pps(1'b1, 4'd8, 8'h00, t, l, pr, po);
        checks++;
        if (po !== 10'h000 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_tick got=%h busy=%b exp=000 busy=0", po, o_busy);
        end
    endtask

    task automatic test_run_stop_mid;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        wr(4'd8, 8'h05);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h011) begin
            failures++;
            $display("FAIL restart got=%h exp=011", po);
        end
        wr(4'd8, 8'h04);
        checks++;
        if (o_busy !== 1'b0 || {o_slot, o_enable, o_selector} !== 10'h000) begin
            failures++;
            $display("FAIL run0_mid got busy=%b out=%h exp 0 000", o_busy, {o_slot, o_enable, o_selector});
        end
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h000 || t !== 1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL run0_later got=%h ticks=%0d busy=%b exp=000 1 0", po, t, o_busy);
        end
    endtask

    task automatic test_reset_mid;
        int t, l;
        logic [7:0] pr;
        logic [9:0] po;
        wr(4'd8, 8'h05);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h011) begin
            failures++;
            $display("FAIL pre_rst got=%h exp=011", po);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || {o_slot, o_enable, o_selector} !== 10'h000) begin
            failures++;
            $display("FAIL rst_mid got busy=%b out=%h exp 0 000", o_busy, {o_slot, o_enable, o_selector});
        end
        rst = 1'b1;
        @(negedge clk);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h000 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_later got=%h busy=%b exp=000 0", po, o_busy);
        end
        wr(4'd8, 8'h01);
        pps(1'b0, 4'd0, 8'd0, t, l, pr, po);
        checks++;
        if (po !== 10'h000 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_table_clear got=%h busy=%b exp=000 1", po, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_slot();
        test_sequence();
        test_dwell_zero();
        test_simultaneous_write();
        test_last_shrink();
        test_stop_on_tick();
        test_run_stop_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
